// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT block loader: default widths, JPEG zigzag table, bank states.
package idct_pkg;

    localparam int DATA_W_DEF       = 16;
    localparam int IDCT_LATENCY_DEF = 29;

    // Scan position n -> raster index
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_st_t;

endpackage

// File: rtl/idct_lat_tag.sv
// Valid delay line tracking blocks through the downstream IDCT; output is input delayed DEPTH cycles.
// No backpressure: one tag per cycle, cleared by reset so nothing in flight survives it.
module idct_lat_tag #(
    parameter int DEPTH = 29
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign tag_out = sr[DEPTH-1];

endmodule

// File: rtl/idct_block_loader.sv
// Ping-pong zigzag-to-raster 8x8 loader; blk_valid 1 cycle after last beat, in_ready low only when both banks FULL.
// Optional early end-of-block (zero-fill remainder) with IDCT_LOADER_EOB_EN.
module idct_block_loader
    import idct_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int IDCT_LATENCY = IDCT_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
`ifdef IDCT_LOADER_EOB_EN
    input  logic                 in_eob,
`endif
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [64*DATA_W-1:0] blk_data,
    output logic                 idct_out_valid
);

    bank_st_t          bank_st     [2];
    bank_st_t          bank_st_nxt [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [5:0]        wr_cnt;
    logic [DATA_W-1:0] mem [2][64];

    logic        in_fire;
    logic        blk_fire;
    logic        fill_done;
    logic        eob;
    logic [63:0] hit;
    logic [63:0] zfill;

`ifdef IDCT_LOADER_EOB_EN
    assign eob = in_eob;
`else
    assign eob = 1'b0;
`endif

    assign in_ready  = (bank_st[wr_ptr] != BANK_FULL);
    assign blk_valid = (bank_st[rd_ptr] == BANK_FULL);
    assign in_fire   = in_valid && in_ready;
    assign blk_fire  = blk_valid && blk_ready;
    assign fill_done = in_fire && ((wr_cnt == 6'd63) || eob);

    // Write and read banks are never the same bank when both fire, so both updates apply.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_nxt[b] = bank_st[b];
            if (blk_fire && (rd_ptr == 1'(b))) begin
                bank_st_nxt[b] = BANK_EMPTY;
            end
            if (in_fire && (wr_ptr == 1'(b))) begin
                bank_st_nxt[b] = fill_done ? BANK_FULL : BANK_FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st <= '{default: BANK_EMPTY};
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_cnt  <= 6'd0;
        end else begin
            bank_st <= bank_st_nxt;
            if (fill_done) begin
                wr_ptr <= ~wr_ptr;
                wr_cnt <= 6'd0;
            end else if (in_fire) begin
                wr_cnt <= wr_cnt + 6'd1;
            end
            if (blk_fire) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Positions past the EOB beat in scan order are cleared so stale data never leaks out.
    always_comb begin
        hit   = '0;
        zfill = '0;
        hit[ZZ[wr_cnt]] = 1'b1;
`ifdef IDCT_LOADER_EOB_EN
        for (int m = 0; m < 64; m++) begin
            if (eob && (6'(m) > wr_cnt)) begin
                zfill[ZZ[m]] = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 64; r++) begin
                    if ((wr_ptr == 1'(b)) && (hit[r] || zfill[r])) begin
                        mem[b][r] <= hit[r] ? in_data : '0;
                    end
                end
            end
        end
    end

    always_comb begin
        blk_data = '0;
        for (int r = 0; r < 64; r++) begin
            blk_data[DATA_W*r +: DATA_W] = mem[rd_ptr][r];
        end
    end

    idct_lat_tag #(
        .DEPTH (IDCT_LATENCY)
    ) u_lat_tag (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (blk_fire),
        .tag_out (idct_out_valid)
    );

endmodule

// File: tb/tb_idct_block_loader.sv
// Bench for idct_block_loader: queue-based block model, fixed raster table, corner sequences.
module tb_idct_block_loader;

    localparam int DW  = 16;
    localparam int LAT = 29;
    typedef logic [64*DW-1:0] blk_t;

    typedef struct {
        int raster;
        int value;
    } elem_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [DW-1:0] in_data = '0;
    logic blk_valid;
    logic blk_ready = 1'b0;
    blk_t blk_data;
    logic idct_out_valid;
`ifdef IDCT_LOADER_EOB_EN
    logic in_eob = 1'b0;
`endif

    always #5 clk = ~clk;

    idct_block_loader #(.DATA_W(DW), .IDCT_LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
`ifdef IDCT_LOADER_EOB_EN
        .in_eob         (in_eob),
`endif
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_data       (blk_data),
        .idct_out_valid (idct_out_valid)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   zz [64];
    blk_t part;
    int   pcnt;
    blk_t full_q [$];
    int   due_q [$];
    int   xfers = 0;
    int   rdy_drops = 0;
    int   ov_cnt = 0;
    int   dut_acc_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t act, input blk_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        part = '0;
        pcnt = 0;
        full_q.delete();
        due_q.delete();
    endtask

    // One clock: drive, check against model, clock, update model. acc reports model acceptance.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic br, input logic e,
                        output logic acc);
        logic bt;
        logic exp_ov;
        in_valid  = v;
        in_data   = d;
        blk_ready = br;
`ifdef IDCT_LOADER_EOB_EN
        in_eob    = e;
`endif
        #1;
        while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
        exp_ov = (due_q.size() > 0 && due_q[0] == cyc);
        chk("in_ready", 64'(in_ready), 64'(full_q.size() < 2));
        chk("blk_valid", 64'(blk_valid), 64'(full_q.size() > 0));
        chk("idct_out_valid", 64'(idct_out_valid), 64'(exp_ov));
        if (full_q.size() > 0) chk_blk("blk_data", blk_data, full_q[0]);
        if (!in_ready) rdy_drops++;
        if (idct_out_valid) ov_cnt++;
        if (in_valid && in_ready) dut_acc_cnt++;
        acc = v && (full_q.size() < 2);
        bt  = br && (full_q.size() > 0);
        @(posedge clk);
        if (bt) begin
            void'(full_q.pop_front());
            due_q.push_back(cyc + LAT);
            xfers++;
        end
        if (acc) begin
            part[zz[pcnt]*DW +: DW] = d;
            if (pcnt == 63 || e) begin
                full_q.push_back(part);
                part = '0;
                pcnt = 0;
            end else begin
                pcnt++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        blk_ready = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_idct_out_valid", 64'(idct_out_valid), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        rst_n = 1'b1;
    endtask

    function automatic blk_t build_blk(input logic [DW-1:0] w [64]);
        blk_t b = '0;
        for (int n = 0; n < 64; n++) b[zz[n]*DW +: DW] = w[n];
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        elem_vec_t tbl [10];
        logic acc;
        logic [DW-1:0] words [64];
        logic [DW-1:0] pend [$];
        blk_t exp0;
        int k, snap, snap2, snap3, guard;

        // Zigzag walk over anti-diagonals, alternating direction.
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = r*8 + (s - r); k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz[k] = r*8 + (s - r); k++;
                end
            end
        end

        tbl[0] = '{0, 0};   tbl[1] = '{1, 1};   tbl[2] = '{8, 2};   tbl[3] = '{16, 3};
        tbl[4] = '{9, 4};   tbl[5] = '{2, 5};   tbl[6] = '{7, 28};  tbl[7] = '{56, 35};
        tbl[8] = '{62, 62}; tbl[9] = '{63, 63};

        model_reset();
        #1;
        do_reset();

        // Ramp block: beat n = n, consumer always ready.
        for (int n = 0; n < 64; n++) tick(1'b1, DW'(n), 1'b1, 1'b0, acc);
        chk("ramp_blk_valid", 64'(blk_valid), 64'd1);
        for (int i = 0; i < 10; i++)
            chk($sformatf("raster_%0d", tbl[i].raster),
                64'(blk_data[tbl[i].raster*DW +: DW]), 64'(tbl[i].value));
        snap = ov_cnt;
        for (int i = 0; i < 35; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("ramp_ov_pulses", 64'(ov_cnt - snap), 64'd1);

        // Three blocks against a stalled consumer.
        for (int i = 0; i < 192; i++) pend.push_back(DW'($urandom));
        for (int n = 0; n < 64; n++) words[n] = pend[n];
        exp0 = build_blk(words);
        snap = dut_acc_cnt;
        for (int i = 0; i < 140; i++) begin
            tick(1'b1, pend[0], 1'b0, 1'b0, acc);
            if (acc) void'(pend.pop_front());
        end
        chk("stall_accepted", 64'(dut_acc_cnt - snap), 64'd128);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk_blk("blk0_held", blk_data, exp0);
        snap = xfers;
        guard = 0;
        while (pend.size() > 0 && guard < 400) begin
            tick(1'b1, pend[0], 1'b1, 1'b0, acc);
            if (acc) void'(pend.pop_front());
            guard++;
        end
        chk("stall_drain_timeout", 64'(pend.size()), 64'd0);
        for (int i = 0; i < 70; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("stall_blocks_out", 64'(xfers - snap), 64'd3);

        // Back-to-back streaming.
        snap = xfers; snap2 = rdy_drops;
        for (int i = 0; i < 192; i++) tick(1'b1, DW'($urandom), 1'b1, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("b2b_in_ready_drops", 64'(rdy_drops - snap2), 64'd0);
        chk("b2b_blocks", 64'(xfers - snap), 64'd3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic e;
            e = 1'b0;
`ifdef IDCT_LOADER_EOB_EN
            e = ($urandom_range(0, 40) == 0);
`endif
            tick($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, e, acc);
        end
        for (int i = 0; i < 200; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);

        // Reset mid-block with a tag in flight.
        for (int n = 0; n < 95; n++) tick(1'b1, DW'($urandom), 1'b0, 1'b0, acc);
        tick(1'b0, '0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0, 1'b0, acc);
        do_reset();
        snap3 = ov_cnt;
        for (int i = 0; i < 40; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
        chk("post_reset_ov", 64'(ov_cnt - snap3), 64'd0);
        for (int n = 0; n < 64; n++) begin
            words[n] = DW'($urandom);
            tick(1'b1, words[n], 1'b0, 1'b0, acc);
        end
        chk("post_reset_blk_valid", 64'(blk_valid), 64'd1);
        chk_blk("post_reset_blk", blk_data, build_blk(words));
        for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);

`ifdef IDCT_LOADER_EOB_EN
        // DC-only block through an early EOB into a dirty bank.
        for (int n = 0; n < 64; n++) tick(1'b1, DW'($urandom | 1), 1'b1, 1'b0, acc);
        for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
        for (int n = 0; n < 64; n++) tick(1'b1, DW'($urandom | 1), 1'b1, 1'b0, acc);
        for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
        tick(1'b1, 16'hFF10, 1'b0, 1'b1, acc);
        chk("eob_blk_valid", 64'(blk_valid), 64'd1);
        begin
            blk_t dc;
            dc = '0;
            dc[DW-1:0] = 16'hFF10;
            chk_blk("eob_dc_only", blk_data, dc);
        end
        for (int i = 0; i < 40; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idct_block_loader.md
IDCT_BLOCK_LOADER -- requirements
Module: idct_block_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: coefficient width, signed.
REQ-002 The block SHALL have parameter IDCT_LATENCY, default 29: downstream IDCT pipeline depth in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data holds a coefficient.
REQ-006 The block SHALL have port in_ready, output, 1 bit: loader accepts a coefficient this cycle.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: coefficient in zigzag scan order.
REQ-008 The block SHALL have port in_eob, input, 1 bit: end-of-block marker; present only with IDCT_LOADER_EOB_EN.
REQ-009 The block SHALL have port blk_valid, output, 1 bit: a complete 8x8 block is presented.
REQ-010 The block SHALL have port blk_ready, input, 1 bit: consumer takes the block.
REQ-011 The block SHALL have port blk_data, output, 64*DATA_W bits: raster-order block; element r occupies bits [DATA_W*r+DATA_W-1 : DATA_W*r], feeding IDCT inputs x0..x63.
REQ-012 The block SHALL have port idct_out_valid, output, 1 bit: the IDCT outputs out0..out63 hold the result of a transferred block.

Function
REQ-013 An input beat SHALL transfer when in_valid and in_ready are both 1; a block SHALL transfer when blk_valid and blk_ready are both 1.
REQ-014 The block SHALL use two banks (ping-pong), each 64 x DATA_W, each in state EMPTY, FILLING or FULL.
REQ-015 Transitions: EMPTY->FILLING on the first beat written; FILLING->FULL on beat 63 (or on EOB); FULL->EMPTY on block transfer.
REQ-016 Beat n (0..63, 6-bit write counter) SHALL be written to raster index ZZ[n], where ZZ is the standard JPEG zigzag table (ZZ[0..5]=0,1,8,16,9,2).
REQ-017 The write counter SHALL wrap to 0 and the write pointer SHALL toggle banks when a bank becomes FULL.
REQ-018 in_ready SHALL be 1 iff the write-pointer bank is EMPTY or FILLING; it is combinational from registered state only, with no dependence on in_valid.
REQ-019 blk_valid SHALL be 1 iff the read-pointer bank is FULL.
REQ-020 blk_data SHALL be that bank's contents and SHALL be stable while blk_valid=1 and blk_ready=0.
REQ-021 The read pointer SHALL toggle on each block transfer; blocks SHALL leave in arrival order.
REQ-022 Fill-complete on one bank and transfer of the other bank in the same cycle SHALL both take effect, with no lost beat or bubble.
REQ-023 With blk_ready held at 1, the block SHALL sustain 1 coefficient per cycle: a block every 64 cycles, first blk_valid 1 cycle after beat 63.
REQ-024 idct_out_valid SHALL equal the block-transfer event delayed by exactly IDCT_LATENCY cycles, via a shift register.
REQ-025 Beats offered while in_ready=0 SHALL NOT be written, and the counter SHALL NOT advance.

Reset
REQ-026 On rst_n=0, asynchronously: banks EMPTY, pointers 0, counter 0, latency shift register cleared.
REQ-027 Reset values SHALL be in_ready=1, blk_valid=0, idct_out_valid=0. blk_data after reset is don't-care.
REQ-028 Reset mid-block or mid-latency SHALL discard the partial block and in-flight tags; no idct_out_valid SHALL follow reset.
REQ-029 Bank storage SHALL NOT require reset. Every position SHALL be written, or zero-filled, before the bank is FULL.

Configuration
REQ-030 With IDCT_LOADER_EOB_EN defined: a beat with in_eob=1 at index n writes ZZ[n], zero-fills all remaining positions, and marks the bank FULL in that same cycle. EOB on beat 0 yields a DC-only block.
REQ-031 Without IDCT_LOADER_EOB_EN: the in_eob port is absent, and exactly 64 beats form a block.

Structure
REQ-032 Package idct_pkg SHALL hold DATA_W and IDCT_LATENCY defaults, the 64-entry ZZ table constant, and the bank-state enum.
REQ-033 A sub-module idct_lat_tag (parameterized-depth valid delay line) SHALL implement REQ-024.

Verification
REQ-034 Feed 64 beats with in_data=n (n=0..63) and blk_ready=1 -> one cycle later blk_valid=1, element ZZ[n] equals n (raster[8]=2, raster[1]=1), and idct_out_valid pulses 29 cycles after the transfer.
REQ-035 Hold blk_ready=0 and stream 3 blocks -> in_ready falls after beat 127; blk_data for block 0 stays constant; after blk_ready=1, blocks are delivered 0,1,2 with no loss.
REQ-036 Back-to-back blocks with blk_ready=1 and in_valid=1 continuous -> in_ready never drops, and blk_valid pulses every 64 cycles.
REQ-037 Assert rst_n=0 after beat 30 and during an in-flight tag -> in_ready=1, blk_valid=0, no idct_out_valid; the next 64 beats form a clean block.
REQ-038 With IDCT_LOADER_EOB_EN: beat 0 = -240 with in_eob=1 -> blk_valid next cycle; raster[0]=-240 and all other elements 0.
